// File: rtl/mdu_multicycle.sv
// mdu_multicycle: execute-stage multiply/divide unit with per-class latency.
// Results are computed into shadow registers when an op is accepted and are
// copied to HI/LO on the edge where busy falls. mthi/mtlo write immediately.
// Optional build macro: MDU_DIV0_FLAG_EN adds a sticky divide-by-zero flag
// output (o_div0); without it the port and its logic are absent.
// MUL_CYCLES and DIV_CYCLES must lie in 1..15 (4-bit down-counter).
module mdu_multicycle #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             o_div0
`endif
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [3:0] MUL_L = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_L = 4'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [W-1:0]   r_sh_hi;
    logic [W-1:0]   r_sh_lo;
    logic           r_commit;

    logic           w_accept;
    logic           w_is_mul_class;
    logic           w_is_div_class;
    logic           w_is_arith;
    logic           w_mul_signed;
    logic           w_div_signed;
    logic           w_div_zero;
    logic [W2-1:0]  w_a_ext;
    logic [W2-1:0]  w_b_ext;
    logic [W2-1:0]  w_prod;
    logic [W2-1:0]  w_acc;
    logic [W2-1:0]  w_mul_res;
    logic           w_dvd_neg;
    logic           w_dvs_neg;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W-1:0]   w_mag_b_safe;
    logic [W-1:0]   w_q_mag;
    logic [W-1:0]   w_r_mag;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_res_hi;
    logic [W-1:0]   w_res_lo;

    // Acceptance gate: only from idle, and never while an exception is pending.
    assign w_accept = i_start & ~i_req & (r_state == S_IDLE);

    // Operation class decode.
    always_comb begin
        w_is_mul_class = 1'b0;
        w_is_div_class = 1'b0;
        w_mul_signed   = 1'b0;
        w_div_signed   = 1'b0;
        unique case (i_op)
            OP_MULT, OP_MADD, OP_MSUB: begin
                w_is_mul_class = 1'b1;
                w_mul_signed   = 1'b1;
            end
            OP_MULTU, OP_MADDU, OP_MSUBU: begin
                w_is_mul_class = 1'b1;
            end
            OP_DIV: begin
                w_is_div_class = 1'b1;
                w_div_signed   = 1'b1;
            end
            OP_DIVU: begin
                w_is_div_class = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_is_arith = w_is_mul_class | w_is_div_class;

    // One 2W-bit multiplier serves both signednesses: sign- or zero-extend
    // the operands and keep the low 2W bits of the product.
    always_comb begin
        w_a_ext = {{W{w_mul_signed & i_a[W-1]}}, i_a};
        w_b_ext = {{W{w_mul_signed & i_b[W-1]}}, i_b};
        w_prod  = W2'(w_a_ext * w_b_ext);
        w_acc   = {o_hi, o_lo};
        unique case (i_op)
            OP_MADD, OP_MADDU: w_mul_res = w_acc + w_prod;
            OP_MSUB, OP_MSUBU: w_mul_res = w_acc - w_prod;
            default:           w_mul_res = w_prod;
        endcase
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. min / -1 falls out as lo=min, hi=0.
    always_comb begin
        w_div_zero   = (i_b == '0);
        w_dvd_neg    = w_div_signed & i_a[W-1];
        w_dvs_neg    = w_div_signed & i_b[W-1];
        w_mag_a      = w_dvd_neg ? W'(-i_a) : i_a;
        w_mag_b      = w_dvs_neg ? W'(-i_b) : i_b;
        w_mag_b_safe = w_div_zero ? W'(1) : w_mag_b;
        w_q_mag      = w_mag_a / w_mag_b_safe;
        w_r_mag      = w_mag_a % w_mag_b_safe;
        w_quot       = (w_dvd_neg ^ w_dvs_neg) ? W'(-w_q_mag) : w_q_mag;
        w_rem        = w_dvd_neg ? W'(-w_r_mag) : w_r_mag;
    end

    // Select the shadow value for the accepted arithmetic op.
    always_comb begin
        w_res_hi = w_mul_res[W2-1:W];
        w_res_lo = w_mul_res[W-1:0];
        if (w_is_div_class) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    // Control FSM with registered busy, HI/LO and shadow state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_sh_hi  <= '0;
            r_sh_lo  <= '0;
            r_commit <= 1'b0;
            o_busy   <= 1'b0;
            o_hi     <= '0;
            o_lo     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_op == OP_MTHI) begin
                            o_hi <= i_a;
                        end else if (i_op == OP_MTLO) begin
                            o_lo <= i_a;
                        end else if (w_is_arith) begin
                            r_sh_hi  <= w_res_hi;
                            r_sh_lo  <= w_res_lo;
                            r_commit <= ~(w_is_div_class & w_div_zero);
                            r_cnt    <= w_is_div_class ? DIV_L : MUL_L;
                            o_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_commit) begin
                            o_hi <= r_sh_hi;
                            o_lo <= r_sh_lo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    // Sticky divide-by-zero flag, rewritten by every accepted op 0-9.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_div0 <= 1'b0;
        end else if (w_accept && (w_is_arith || i_op == OP_MTHI || i_op == OP_MTLO)) begin
            o_div0 <= w_is_div_class & w_div_zero;
        end
    end
`endif

endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle: directed ops push their expected
// HI/LO, busy length and div0 into a queue; a monitor pops on each busy fall.
module tb_mdu_multicycle;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic        i_start;
    logic [3:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
`ifdef MDU_DIV0_FLAG_EN
    logic        o_div0;
`endif

    mdu_multicycle #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .o_div0  (o_div0)
`endif
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        logic        d0;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int len, input logic d0);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.len = len;
        e.d0  = d0;
        sb.push_back(e);
    endtask

    // Present one op for a single clock edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    // Bounded wait for the unit to go idle with every expectation consumed.
    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (!o_busy && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check({name, "_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: measure busy length, watch HI/LO hold while busy, score on fall.
    int          run_len  = 0;
    bit          was_busy = 1'b0;
    bit          hold_bad = 1'b0;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    always @(negedge clk) begin
        if (reset) begin
            run_len  = 0;
            was_busy = 1'b0;
            hold_bad = 1'b0;
        end else begin
            if (o_busy) begin
                if (!was_busy) begin
                    hold_hi = o_hi;
                    hold_lo = o_lo;
                end
                run_len++;
                if (o_hi !== hold_hi || o_lo !== hold_lo) hold_bad = 1'b1;
            end else if (was_busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_hilo", {o_hi, o_lo}, {e.hi, e.lo});
                    check("busy_len", 64'(run_len), 64'(e.len));
                    check("hilo_held_while_busy", 64'(hold_bad), 64'd0);
`ifdef MDU_DIV0_FLAG_EN
                    check("div0_flag", 64'(o_div0), 64'(e.d0));
`endif
                end
                run_len  = 0;
                hold_bad = 1'b0;
            end
            was_busy = o_busy;
        end
    end

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_start = 1'b0;
        i_op    = 4'd0;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_hilo", {o_hi, o_lo}, 64'd0);
`ifdef MDU_DIV0_FLAG_EN
        check("reset_div0", 64'(o_div0), 64'd0);
`endif
        reset = 1'b0;

        // mult -2 * 3
        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
        issue(4'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done("mult");

        // divu 100 / 7
        push(32'd2, 32'd14, 10, 1'b0);
        issue(4'd3, 32'd100, 32'd7);
        wait_done("divu");

        // div -7 / 2
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
        issue(4'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg");

        // div min / -1
        push(32'h0, 32'h8000_0000, 10, 1'b0);
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf");

        // mthi 5, mtlo 1: immediate, no busy
        issue(4'd4, 32'd5, 32'd0);
        @(negedge clk);
        check("mthi_busy", 64'(o_busy), 64'd0);
        check("mthi_hi", 64'(o_hi), 64'd5);
        issue(4'd5, 32'd1, 32'd0);
        @(negedge clk);
        check("mtlo_busy", 64'(o_busy), 64'd0);
        check("mtlo_hilo", {o_hi, o_lo}, {32'd5, 32'd1});

        // madd 2*3, then msubu 8*1
        push(32'd5, 32'd7, 5, 1'b0);
        issue(4'd6, 32'd2, 32'd3);
        wait_done("madd");
        push(32'd4, 32'hFFFF_FFFF, 5, 1'b0);
        issue(4'd9, 32'd8, 32'd1);
        wait_done("msubu");

        // divide by zero keeps hi=1, lo=2
        issue(4'd4, 32'd1, 32'd0);
        issue(4'd5, 32'd2, 32'd0);
        push(32'd1, 32'd2, 10, 1'b1);
        issue(4'd2, 32'd9, 32'd0);
        wait_done("div0");

        // start with req pending is not accepted
        i_req = 1'b1;
        issue(4'd0, 32'd7, 32'd6);
        i_req = 1'b0;
        @(negedge clk);
        check("req_block_busy", 64'(o_busy), 64'd0);
        check("req_block_hilo", {o_hi, o_lo}, {32'd1, 32'd2});
`ifdef MDU_DIV0_FLAG_EN
        check("div0_sticky", 64'(o_div0), 64'd1);
`endif

        // mult 7*6 with req pulse and a competing start mid-run
        push(32'd0, 32'd42, 5, 1'b0);
        issue(4'd0, 32'd7, 32'd6);
        @(negedge clk);
        i_req = 1'b1;
        @(negedge clk);
        i_req   = 1'b0;
        i_op    = 4'd3;
        i_a     = 32'd1;
        i_b     = 32'd1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_mid_run", 64'(o_busy), 64'd1);
        wait_done("mult_req_mid");

        // op 12 has no effect
        issue(4'd12, 32'hDEAD_BEEF, 32'd3);
        @(negedge clk);
        check("noop_busy", 64'(o_busy), 64'd0);
        check("noop_hilo", {o_hi, o_lo}, {32'd0, 32'd42});

        // reset three cycles into a divide discards it
        issue(4'd3, 32'd50, 32'd5);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        check("rst_mid_hilo", {o_hi, o_lo}, 64'd0);
        reset = 1'b0;

        // ops after reset, including signed msub and unsigned wrap
        push(32'd0, 32'd12, 5, 1'b0);
        issue(4'd0, 32'd3, 32'd4);
        wait_done("mult_after_rst");
        push(32'd0, 32'd13, 5, 1'b0);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1);
        wait_done("msub");
        push(32'hFFFF_FFFE, 32'h0000_0001, 5, 1'b0);
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu");
        push(32'hFFFF_FFFC, 32'h0000_0002, 5, 1'b0);
        issue(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("maddu_wrap");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
